// File: rtl/matrix_key_sequencer.sv
// Remote key-matrix sequencer: queues press/release/tap commands and replays them
// onto a pressed-key bitmap, with millisecond hold times and a mandatory idle gap.
module matrix_key_sequencer #(
  parameter int ROW_NUM    = 4,
  parameter int COL_NUM    = 4,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_MS     = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int KEY_W      = $clog2(ROW_NUM*COL_NUM)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ctrl_enable,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [KEY_W-1:0]            cmd_key,
  input  logic [15:0]                 cmd_hold_ms,
  output logic [ROW_NUM*COL_NUM-1:0]  key_in,
  output logic                        key_ctrl_enable,
  output logic                        busy,
  output logic                        cmd_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int KEYS    = ROW_NUM*COL_NUM;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENT_W   = 2 + KEY_W + 16;
  localparam int PRESC_W = $clog2(TICK_DIV + 1);

  localparam logic [1:0] OP_PRESS       = 2'b00;
  localparam logic [1:0] OP_RELEASE     = 2'b01;
  localparam logic [1:0] OP_TAP         = 2'b10;
  localparam logic [1:0] OP_RELEASE_ALL = 2'b11;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  state_t state_reg, state_next;

  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     level_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [15:0]        ms_reg, hold_target_reg;
  logic [KEY_W-1:0]   cur_key_reg;
  logic [KEYS-1:0]    key_reg, key_next;
  logic               err_reg, err_next, kce_reg;
  logic               push, pop, restart_wait, tick_last, hold_done, gap_done;
  logic [1:0]         head_op;
  logic [KEY_W-1:0]   head_key;
  logic [15:0]        head_hold;

  assign cmd_ready = rstn && ctrl_enable && (level_reg < (PTR_W+1)'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign {head_op, head_key, head_hold} = fifo_mem[rd_ptr_reg];

  assign key_in          = key_reg;
  assign key_ctrl_enable = kce_reg;
  assign cmd_err         = err_reg;
  assign fifo_level      = level_reg;
  assign busy            = (state_reg != IDLE) || (level_reg != '0);

  assign tick_last = (presc_reg == PRESC_W'(TICK_DIV - 1));
  assign hold_done = tick_last && (ms_reg == hold_target_reg - 16'd1);
  // A zero-length gap still costs one cycle in GAP.
  assign gap_done  = (GAP_MS == 0) || (tick_last && (ms_reg == 16'(GAP_MS - 1)));

  always_ff @(posedge clk) begin
    if (!rstn || !ctrl_enable) state_reg <= IDLE;
    else                       state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    key_next     = key_reg;
    pop          = 1'b0;
    err_next     = 1'b0;
    restart_wait = 1'b0;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          pop = 1'b1;
          if (head_op != OP_RELEASE_ALL && int'(head_key) >= KEYS) begin
            err_next = 1'b1;
          end else begin
            restart_wait = 1'b1;
            state_next   = GAP;
            case (head_op)
              OP_PRESS:   key_next[head_key] = 1'b1;
              OP_RELEASE: key_next[head_key] = 1'b0;
              OP_TAP: begin
                key_next[head_key] = 1'b1;
                state_next         = HOLD;
              end
              default:    key_next = '0;
            endcase
          end
        end
      end
      HOLD: begin
        if (hold_done) begin
          key_next[cur_key_reg] = 1'b0;
          state_next            = GAP;
          restart_wait          = 1'b1;
        end
      end
      GAP: begin
        if (gap_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_key, cmd_hold_ms};
  end

  always_ff @(posedge clk) begin
    if (!rstn) kce_reg <= 1'b0;
    else       kce_reg <= ctrl_enable;
  end

  // Dropping ctrl_enable is a soft abort: same effect as reset on the datapath.
  always_ff @(posedge clk) begin
    if (!rstn || !ctrl_enable) begin
      key_reg         <= '0;
      err_reg         <= 1'b0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      presc_reg       <= '0;
      ms_reg          <= '0;
      hold_target_reg <= 16'd1;
      cur_key_reg     <= '0;
    end else begin
      key_reg   <= key_next;
      err_reg   <= err_next;
      level_reg <= level_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg      <= rd_ptr_reg + PTR_W'(1);
        cur_key_reg     <= head_key;
        hold_target_reg <= (head_hold == 16'd0) ? 16'd1 : head_hold;
      end
      if (restart_wait) begin
        presc_reg <= '0;
        ms_reg    <= '0;
      end else if (state_reg != IDLE) begin
        if (tick_last) begin
          presc_reg <= '0;
          ms_reg    <= ms_reg + 16'd1;
        end else begin
          presc_reg <= presc_reg + PRESC_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_key_sequencer.sv
// Directed and randomised checks of matrix_key_sequencer against a command-queue /
// cycle-countdown reference model; a second 3x4 instance exercises out-of-range keys.
module tb_matrix_key_sequencer;
  localparam int TICK    = 4;
  localparam int GAPM    = 2;
  localparam int DEPTH   = 8;
  localparam int GAP_CYC = (GAPM == 0) ? 1 : GAPM * TICK;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, en, valid, ready, kce, busy, err;
  logic [1:0]  op;
  logic [3:0]  key, level;
  logic [15:0] hold, kin;

  logic        b_en, b_valid, b_ready, b_kce, b_busy, b_err;
  logic [1:0]  b_op;
  logic [3:0]  b_key, b_level;
  logic [15:0] b_hold;
  logic [11:0] b_kin;

  matrix_key_sequencer #(.ROW_NUM(4), .COL_NUM(4), .TICK_DIV(TICK), .GAP_MS(GAPM),
                         .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .ctrl_enable(en), .cmd_valid(valid), .cmd_ready(ready),
    .cmd_op(op), .cmd_key(key), .cmd_hold_ms(hold), .key_in(kin),
    .key_ctrl_enable(kce), .busy(busy), .cmd_err(err), .fifo_level(level));

  matrix_key_sequencer #(.ROW_NUM(3), .COL_NUM(4), .TICK_DIV(TICK), .GAP_MS(GAPM),
                         .FIFO_DEPTH(DEPTH)) dut3 (
    .clk(clk), .rstn(rstn), .ctrl_enable(b_en), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(b_op), .cmd_key(b_key), .cmd_hold_ms(b_hold), .key_in(b_kin),
    .key_ctrl_enable(b_kce), .busy(b_busy), .cmd_err(b_err), .fifo_level(b_level));

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  key;
    logic [15:0] hold;
  } cmd_t;

  cmd_t        q[$];
  logic [15:0] m_key = '0;
  logic        m_err = 1'b0, m_kce = 1'b0, m_in_hold = 1'b0;
  logic [3:0]  m_hkey = '0;
  int          m_wait = 0;
  int          errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: a queue of pending commands plus "cycles left" in the current activity.
  task automatic model_edge();
    cmd_t c;
    bit   rdy;
    rdy   = rstn && en && (q.size() < DEPTH);
    m_err = 1'b0;
    if (!rstn || !en) begin
      q.delete();
      m_key = '0; m_wait = 0; m_in_hold = 1'b0;
      m_kce = rstn ? en : 1'b0;
      return;
    end
    m_kce = 1'b1;
    if (m_wait == 0) begin
      if (q.size() > 0) begin
        c = q.pop_front();
        case (c.op)
          2'b00: begin m_key[c.key] = 1'b1; m_wait = GAP_CYC; end
          2'b01: begin m_key[c.key] = 1'b0; m_wait = GAP_CYC; end
          2'b10: begin
            m_key[c.key] = 1'b1;
            m_wait = ((c.hold == 16'd0) ? 1 : int'(c.hold)) * TICK;
            m_in_hold = 1'b1;
            m_hkey = c.key;
          end
          default: begin m_key = '0; m_wait = GAP_CYC; end
        endcase
      end
    end else begin
      m_wait--;
      if (m_wait == 0 && m_in_hold) begin
        m_key[m_hkey] = 1'b0;
        m_in_hold = 1'b0;
        m_wait = GAP_CYC;
      end
    end
    if (valid && rdy) begin
      q.push_back('{op, key, hold});
      $display("push op=%0d key=%0d hold=%0d queued=%0d", op, key, hold, q.size());
    end
  endtask

  task automatic check_all();
    chk("key_in", 32'(kin), 32'(m_key));
    chk("fifo_level", 32'(level), 32'(q.size()));
    chk("busy", 32'(busy), 32'((m_wait != 0) || (q.size() != 0)));
    chk("cmd_err", 32'(err), 32'(m_err));
    chk("key_ctrl_enable", 32'(kce), 32'(m_kce));
    chk("cmd_ready", 32'(ready), 32'(rstn && en && (q.size() < DEPTH)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic send(input logic [1:0] o, input logic [3:0] k, input logic [15:0] h);
    op = o; key = k; hold = h; valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; valid = 1'b0; op = '0; key = '0; hold = '0;
    b_en = 1'b0; b_valid = 1'b0; b_op = '0; b_key = '0; b_hold = '0;
    repeat (2) step();
    chk("reset_key_in", 32'(kin), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);
    rstn = 1'b1; en = 1'b1; b_en = 1'b1;
    step();

    // TAP key 5 for 3 ms
    send(2'b10, 4'd5, 16'd3);
    step();
    chk("tap_first", 32'(kin), 32'h0020);
    repeat (11) step();
    chk("tap_last", 32'(kin), 32'h0020);
    step();
    chk("tap_release", 32'(kin), 32'h0000);
    repeat (7) step();
    chk("tap_gap_busy", 32'(busy), 32'h1);
    step();
    chk("tap_idle", 32'(busy), 32'h0);

    // PRESS 0, PRESS 15, RELEASE_ALL back to back
    send(2'b00, 4'd0, 16'd0);
    send(2'b00, 4'd15, 16'd0);
    send(2'b11, 4'd7, 16'd0);
    repeat (7) step();
    chk("seq_step1", 32'(kin), 32'h0001);
    step();
    chk("seq_step2", 32'(kin), 32'h8001);
    repeat (8) step();
    chk("seq_step2_end", 32'(kin), 32'h8001);
    step();
    chk("seq_step3", 32'(kin), 32'h0000);
    repeat (10) step();

    // Push while disabled is refused, then fill the queue behind a TAP of key 3
    en = 1'b0; valid = 1'b1; op = 2'b10; key = 4'd3; hold = 16'd3;
    step();
    chk("disabled_push", 32'(level), 32'h0);
    en = 1'b1;
    step();
    op = 2'b00;
    for (int i = 0; i < 8; i++) begin
      key = 4'($urandom_range(0, 15));
      step();
    end
    chk("full_level", 32'(level), 32'd8);
    chk("full_ready", 32'(ready), 32'h0);
    step();
    chk("full_stable", 32'(level), 32'd8);
    chk("hold_key3", 32'(kin), 32'h0008);
    valid = 1'b0; en = 1'b0;
    step();
    chk("abort_key_in", 32'(kin), 32'h0);
    chk("abort_level", 32'(level), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_kce", 32'(kce), 32'h0);
    en = 1'b1;
    repeat (3) step();

    // TAP with zero hold lasts one ms
    send(2'b10, 4'd9, 16'd0);
    step();
    chk("tap0_set", 32'(kin), 32'h0200);
    repeat (3) step();
    chk("tap0_last", 32'(kin), 32'h0200);
    step();
    chk("tap0_clear", 32'(kin), 32'h0000);
    repeat (9) step();

    // Reset in the middle of a GAP
    send(2'b00, 4'd7, 16'd0);
    repeat (4) step();
    rstn = 1'b0;
    step();
    chk("rst_gap_key_in", 32'(kin), 32'h0);
    chk("rst_gap_kce", 32'(kce), 32'h0);
    chk("rst_gap_busy", 32'(busy), 32'h0);
    chk("rst_gap_ready", 32'(ready), 32'h0);
    rstn = 1'b1;
    step();
    send(2'b10, 4'd2, 16'd1);
    step();
    chk("post_rst_tap", 32'(kin), 32'h0004);
    repeat (4) step();
    chk("post_rst_release", 32'(kin), 32'h0000);
    repeat (9) step();

    // 3x4 instance: key 14 is out of range
    b_op = 2'b00; b_key = 4'd14; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    chk("b_level", 32'(b_level), 32'h1);
    chk("b_err_idle", 32'(b_err), 32'h0);
    step();
    chk("b_err_pulse", 32'(b_err), 32'h1);
    chk("b_key_unchanged", 32'(b_kin), 32'h0);
    chk("b_idle", 32'(b_busy), 32'h0);
    step();
    chk("b_err_end", 32'(b_err), 32'h0);
    b_key = 4'd11; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    chk("b_key11", 32'(b_kin), 32'h800);
    chk("b_busy", 32'(b_busy), 32'h1);
    chk("b_kce", 32'(b_kce), 32'h1);
    chk("b_ready", 32'(b_ready), 32'h1);

    // Randomised traffic with occasional disable and reset
    for (int i = 0; i < 2500; i++) begin
      rstn  = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 79) != 0);
      valid = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom_range(0, 3));
      key   = 4'($urandom_range(0, 15));
      hold  = 16'($urandom_range(0, 3));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
